// File: rtl/serial_tx_if.sv
// Handshake and line signals between a word source and the serial transmitter.
// The source side (master) offers words; the transmitter (slave) drives the line and status.
interface serial_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid;
  logic                  ready;
  logic                  tx;
  logic                  busy;
  logic                  done;

  modport master (
    output data_in,
    output valid,
    input  ready,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_WIDTH data bits LSB first,
// stop bit, each held CLKS_PER_BIT cycles. All outputs are registered.
module serial_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input logic        clk,
  input logic        rst,
  serial_tx_if.slave bus
);

  localparam int unsigned CycW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BitW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CycW-1:0] CycLast = CycW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [CycW-1:0]       cyc_q;
  logic [BitW-1:0]       bit_q;
  logic                  tx_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  bit_end;

  assign shift_nxt = shift_q >> 1;
  assign bit_end   = (cyc_q == CycLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.valid) begin
            shift_q <= bus.data_in;
            cyc_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            cyc_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_q == BitLast) begin
              bit_q   <= '0;
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              // Next bit goes on the line in the same edge that shifts it into place.
              bit_q   <= bit_q + BitW'(1);
              shift_q <= shift_nxt;
              tx_q    <= shift_nxt[0];
            end
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            cyc_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cyc_q   <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (W=8,C=4 and W=5,C=1) checked every cycle against a
// frame-level model, plus hand-computed tx/done timelines for directed frames.
module tb_serial_tx;

  localparam int HistN = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_tx_if #(.DATA_WIDTH(8)) bus0 ();
  serial_tx_if #(.DATA_WIDTH(5)) bus1 ();

  serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  serial_tx #(.DATA_WIDTH(5), .CLKS_PER_BIT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit started = 1'b0;

  // Frame-level model: active flag, position within the frame (1-based cycle), latched word.
  bit         m_act  [2];
  int         m_k    [2];
  bit         m_done [2];
  logic [7:0] m_word [2];
  int         acc0[$];
  int         acc1[$];

  logic tx_h0 [HistN];
  logic rdy_h0[HistN];
  logic bsy_h0[HistN];
  logic dn_h0 [HistN];
  logic tx_h1 [HistN];
  logic dn_h1 [HistN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int n, input int w, input int c, input bit r, input bit v,
                            input logic [7:0] d);
    if (r) begin
      m_act[n]  = 1'b0;
      m_done[n] = 1'b0;
    end else if (m_act[n]) begin
      m_k[n]++;
      if (m_k[n] > (w + 2) * c) begin
        m_act[n]  = 1'b0;
        m_done[n] = 1'b1;
      end
    end else begin
      m_done[n] = 1'b0;
      if (v) begin
        m_act[n]  = 1'b1;
        m_k[n]    = 1;
        m_word[n] = d;
        // Recorded as t0: the cycle whose closing edge accepts the word.
        if (n == 0) acc0.push_back(cyc - 1);
        else        acc1.push_back(cyc - 1);
      end
    end
  endtask

  function automatic logic exp_tx(input int n, input int w, input int c);
    int j;
    if (!m_act[n]) return 1'b1;
    j = (m_k[n] - 1) / c;
    if (j == 0) return 1'b0;
    if (j <= w) return m_word[n][j-1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] decode0(input int t0);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = tx_h0[t0 + 4 * (i + 1) + 2];
    return w;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) started = 1'b1;
    model_step(0, 8, 4, rst, bus0.valid, bus0.data_in);
    model_step(1, 5, 1, rst, bus1.valid, {3'b000, bus1.data_in});
  end

  always @(negedge clk) begin
    if (started) begin
      if (cyc < HistN) begin
        tx_h0[cyc]  = bus0.tx;
        rdy_h0[cyc] = bus0.ready;
        bsy_h0[cyc] = bus0.busy;
        dn_h0[cyc]  = bus0.done;
        tx_h1[cyc]  = bus1.tx;
        dn_h1[cyc]  = bus1.done;
      end
      chk("tx0",    bus0.tx,    exp_tx(0, 8, 4));
      chk("ready0", bus0.ready, !m_act[0]);
      chk("busy0",  bus0.busy,  m_act[0]);
      chk("done0",  bus0.done,  m_done[0]);
      chk("tx1",    bus1.tx,    exp_tx(1, 5, 1));
      chk("ready1", bus1.ready, !m_act[1]);
      chk("busy1",  bus1.busy,  m_act[1]);
      chk("done1",  bus1.done,  m_done[1]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_acc0(input int n);
    int lim = 0;
    while (acc0.size() < n && lim < 300) begin
      tick();
      lim++;
    end
    chk("accept_seen0", 32'(acc0.size() >= n), 1);
  endtask

  task automatic wait_idle();
    int lim = 0;
    while ((m_act[0] || m_act[1]) && lim < 500) begin
      tick();
      lim++;
    end
    chk("idle_reached", 32'(m_act[0] || m_act[1]), 0);
    repeat (3) tick();
  endtask

  initial begin
    int r0, a1, a2, t0, dn_cnt;
    logic [9:0] pat;
    logic [6:0] pat6;

    bus0.valid = 1'b0; bus0.data_in = '0;
    bus1.valid = 1'b0; bus1.data_in = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Idle after reset.
    r0 = cyc;
    repeat (21) tick();
    for (int i = 0; i < 20; i++) begin
      chk("idle_tx",    tx_h0[r0 + i],  1);
      chk("idle_ready", rdy_h0[r0 + i], 1);
      chk("idle_busy",  bsy_h0[r0 + i], 0);
      chk("idle_done",  dn_h0[r0 + i],  0);
    end

    // Single 0xA5 frame.
    acc0.delete();
    bus0.data_in = 8'hA5; bus0.valid = 1'b1;
    tick();
    bus0.valid = 1'b0;
    wait_acc0(1);
    t0 = acc0[0];
    repeat (45) tick();
    pat = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < 10; j++) chk("a5_bit", tx_h0[t0 + 4 * j + 2], pat[j]);
    dn_cnt = 0;
    for (int i = t0 + 1; i <= t0 + 40; i++) dn_cnt += int'(bsy_h0[i]);
    chk("a5_busy_len",   dn_cnt, 40);
    chk("a5_done",       dn_h0[t0 + 41], 1);
    chk("a5_done_ready", rdy_h0[t0 + 41], 1);
    chk("a5_done_prev",  dn_h0[t0 + 40], 0);

    // Back-to-back 0x00 then 0xFF with valid held high.
    acc0.delete();
    bus0.data_in = 8'h00; bus0.valid = 1'b1;
    wait_acc0(1);
    bus0.data_in = 8'hFF;
    wait_acc0(2);
    bus0.valid = 1'b0;
    a1 = acc0[0]; a2 = acc0[1];
    wait_idle();
    chk("b2b_gap",    a2, a1 + 41);
    chk("b2b_idle",   tx_h0[a1 + 41], 1);
    chk("b2b_start",  tx_h0[a2 + 1], 0);
    chk("b2b_done1",  dn_h0[a1 + 41], 1);
    chk("b2b_done2",  dn_h0[a2 + 41], 1);
    chk("b2b_word1",  decode0(a1), 8'h00);
    chk("b2b_word2",  decode0(a2), 8'hFF);

    // data_in changes mid-frame.
    acc0.delete();
    bus0.data_in = 8'hA5; bus0.valid = 1'b1;
    wait_acc0(1);
    a1 = acc0[0];
    while (cyc < a1 + 10) tick();
    bus0.data_in = 8'h3C;
    wait_acc0(2);
    bus0.valid = 1'b0;
    a2 = acc0[1];
    wait_idle();
    chk("mid_word1",  decode0(a1), 8'hA5);
    chk("mid_accept", a2, a1 + 41);
    chk("mid_word2",  decode0(a2), 8'h3C);

    // Reset during data bit 3.
    acc0.delete();
    bus0.data_in = 8'h5A; bus0.valid = 1'b1;
    tick();
    bus0.valid = 1'b0;
    wait_acc0(1);
    t0 = acc0[0];
    while (cyc < t0 + 17) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (60) tick();
    chk("rst_tx",    tx_h0[t0 + 18],  1);
    chk("rst_ready", rdy_h0[t0 + 18], 1);
    chk("rst_busy",  bsy_h0[t0 + 18], 0);
    chk("rst_bit3",  tx_h0[t0 + 17],  1'b1);
    dn_cnt = 0;
    for (int i = t0; i < t0 + 60; i++) dn_cnt += int'(dn_h0[i]);
    chk("rst_no_done", dn_cnt, 0);

    // Randomized traffic on both instances, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      bus0.valid   = ($urandom_range(0, 2) == 0);
      bus0.data_in = 8'($urandom);
      bus1.valid   = ($urandom_range(0, 2) == 0);
      bus1.data_in = 5'($urandom);
      rst          = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    bus0.valid = 1'b0;
    bus1.valid = 1'b0;
    wait_idle();

    // W=5, C=1 instance sends 0x13.
    acc1.delete();
    bus1.data_in = 5'h13; bus1.valid = 1'b1;
    tick();
    bus1.valid = 1'b0;
    repeat (12) tick();
    chk("w5_accept_seen", 32'(acc1.size()), 1);
    if (acc1.size() > 0) begin
      t0 = acc1[0];
      pat6 = {1'b1, 5'h13, 1'b0};
      for (int i = 0; i < 7; i++) chk("w5_bit", tx_h1[t0 + 1 + i], pat6[i]);
      chk("w5_done",      dn_h1[t0 + 8], 1);
      chk("w5_done_prev", dn_h1[t0 + 7], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
